// File: rtl/packet_rr_arbiter_pkg.sv
// Shared types for the UART packet arbiter: the packet beat format and the arbiter state.
package packet_rr_arbiter_pkg;

  typedef struct packed {
    logic [7:0] Data;
    logic       Valid;
    logic       SoP;
    logic       EoP;
  } UART_PACKET;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} ARB_STATE;

endpackage

// File: rtl/packet_rr_arbiter_if.sv
// Requester-side and UART-side bundle of the packet arbiter.
interface packet_rr_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
);
  import packet_rr_arbiter_pkg::*;

  UART_PACKET [NUM_IN-1:0] ipTxStream;
  logic       [NUM_IN-1:0] opTxReady;
  UART_PACKET              opTxStream;
  logic                    ipTxReady;
  logic       [NUM_IN-1:0] opGrant;
  logic                    opTimeout;
  logic       [CNT_W-1:0]  opDropCount;

  modport master (
    input  ipTxStream, ipTxReady,
    output opTxReady, opTxStream, opGrant, opTimeout, opDropCount
  );

  modport slave (
    output ipTxStream, ipTxReady,
    input  opTxReady, opTxStream, opGrant, opTimeout, opDropCount
  );
endinterface

// File: rtl/packet_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping at N.
module rr_picker #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      // explicit wrap so non-power-of-two N never indexes past N-1
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN UART packet streams with orphan dropping
// and a stalled-owner watchdog.
module packet_rr_arbiter
  import packet_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input logic                 ipClk,
  input logic                 nReset,
  packet_rr_arbiter_if.master bus
);

  localparam int PW = $clog2(NUM_IN);
  localparam int WW = $clog2(TIMEOUT+1);

  ARB_STATE              state, stateNext;
  logic [PW-1:0]         ptr, ptrNext, owner, ownerNext, winIdx;
  logic [NUM_IN-1:0]     resync, resyncNext, req, drop, ready, winOh;
  logic [WW-1:0]         wdCnt, wdNext;
  UART_PACKET            outReg, outNext, ownBeat;
  logic                  toReg, toNext, winVld, slotFree;
  logic [CNT_W-1:0]      dropCnt, dropNext;
  logic [3:0]            dropInc;
  logic [CNT_W:0]        dropSum;

  for (genvar i = 0; i < NUM_IN; i++) begin : gLane
    logic isOwner;
    assign isOwner = (state == LOCKED) && (owner == PW'(i));
    assign req[i]  = bus.ipTxStream[i].Valid && bus.ipTxStream[i].SoP && !resync[i];
    // body beats with no open grant (or awaiting resync) are swallowed
    assign drop[i] = bus.ipTxStream[i].Valid && !bus.ipTxStream[i].SoP && (!isOwner || resync[i]);
  end

  rr_picker #(.N(NUM_IN)) uPick (.req(req), .ptr(ptr), .gnt(winOh), .vld(winVld));

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NUM_IN; i++) if (winOh[i]) winIdx = PW'(i);
  end

  assign slotFree = !outReg.Valid || bus.ipTxReady;
  assign ownBeat  = bus.ipTxStream[owner];

  always_comb begin
    stateNext  = state;
    ptrNext    = ptr;
    ownerNext  = owner;
    resyncNext = resync;
    wdNext     = wdCnt;
    toNext     = 1'b0;
    outNext    = slotFree ? '0 : outReg;
    ready      = drop;
    dropInc    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dropInc = dropInc + {3'b0, drop[i]};
      if (bus.ipTxStream[i].Valid && bus.ipTxStream[i].SoP && resync[i]) resyncNext[i] = 1'b0;
    end
    case (state)
      IDLE: begin
        if (winVld && slotFree) begin
          ready   = ready | winOh;
          outNext = bus.ipTxStream[winIdx];
          if (bus.ipTxStream[winIdx].EoP) begin
            ptrNext = winIdx;
          end else begin
            stateNext = LOCKED;
            ownerNext = winIdx;
            wdNext    = '0;
          end
        end
      end
      LOCKED: begin
        ready[owner] = ready[owner] | slotFree;
        if (ownBeat.Valid && slotFree) begin
          outNext = ownBeat;
          wdNext  = '0;
          if (ownBeat.SoP) dropInc = dropInc + 4'd1;
          if (ownBeat.EoP) begin
            stateNext = IDLE;
            ptrNext   = owner;
          end
        end else if (!ownBeat.Valid) begin
          // only a silent owner ages the watchdog; downstream stalls do not
          if (wdCnt == WW'(TIMEOUT-1)) begin
            toNext            = 1'b1;
            resyncNext[owner] = 1'b1;
            ptrNext           = owner;
            stateNext         = IDLE;
          end else begin
            wdNext = wdCnt + 1'b1;
          end
        end
      end
    endcase
    dropSum  = {1'b0, dropCnt} + (CNT_W+1)'(dropInc);
    dropNext = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
  end

  always_ff @(posedge ipClk) begin
    if (nReset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      resync  <= '0;
      wdCnt   <= '0;
      outReg  <= '0;
      toReg   <= 1'b0;
      dropCnt <= '0;
    end else begin
      state   <= stateNext;
      ptr     <= ptrNext;
      owner   <= ownerNext;
      resync  <= resyncNext;
      wdCnt   <= wdNext;
      outReg  <= outNext;
      toReg   <= toNext;
      dropCnt <= dropNext;
    end
  end

  assign bus.opTxReady   = nReset ? '0 : ready;
  assign bus.opTxStream  = outReg;
  assign bus.opGrant     = (state == LOCKED) ? (NUM_IN'(1) << owner) : '0;
  assign bus.opTimeout   = toReg;
  assign bus.opDropCount = dropCnt;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Scoreboard bench for packet_rr_arbiter: directed scenarios plus randomized multi-source traffic.
module tb_packet_rr_arbiter;
  import packet_rr_arbiter_pkg::*;

  localparam int NUM_IN  = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic ipClk = 1'b0;
  logic nReset;

  packet_rr_arbiter_if #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) bus();

  packet_rr_arbiter #(.NUM_IN(NUM_IN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .ipClk(ipClk), .nReset(nReset), .bus(bus)
  );

  always #5 ipClk = ~ipClk;

  UART_PACKET src [NUM_IN];
  always_comb for (int i = 0; i < NUM_IN; i++) bus.ipTxStream[i] = src[i];

  int         nCmp, nErr, cyc, curSrc, rdyMode, drops;
  bit         tagMode, toSeen, inPkt;
  UART_PACKET expQ[$];
  int         sopSrc[$];
  int         outCycs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic UART_PACKET mk(input logic [7:0] d, input logic s, input logic e);
    UART_PACKET p;
    p.Data = d; p.Valid = 1'b1; p.SoP = s; p.EoP = e;
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge ipClk); #1; end
  endtask

  task automatic sendBeat(input int i, input UART_PACKET b, input bit fwd, output int waited);
    logic acc;
    acc = 1'b0; waited = 0;
    src[i] = b;
    for (int t = 0; t < 400; t++) begin
      @(negedge ipClk); acc = bus.opTxReady[i];
      @(posedge ipClk); #1;
      waited = t;
      if (acc) break;
    end
    if (!acc) begin
      nCmp++; nErr++;
      $display("FAIL beat_wait: input %0d beat %h never accepted, required within 400 cycles", i, b);
    end else if (fwd) expQ.push_back(b);
    src[i] = '0;
  endtask

  task automatic sendPkt(input int i, input int len, input logic [7:0] d0, input int maxGap);
    int w;
    for (int b = 0; b < len; b++) begin
      sendBeat(i, mk(d0 + 8'(b), b == 0, b == len-1), 1'b1, w);
      if (b < len-1 && maxGap > 0) idle($urandom_range(0, maxGap));
    end
  endtask

  task automatic monitor();
    UART_PACKET e;
    int s;
    forever begin
      @(negedge ipClk);
      cyc++;
      if (bus.opTimeout === 1'b1) toSeen = 1'b1;
      if (!tagMode) inPkt = 1'b0;
      if (bus.opTxStream.Valid === 1'b1 && bus.ipTxReady === 1'b1) begin
        outCycs.push_back(cyc);
        s = int'(bus.opTxStream.Data[7:6]);
        if (bus.opTxStream.SoP) sopSrc.push_back(s);
        if (expQ.size() == 0) begin
          nCmp++; nErr++;
          $display("FAIL out_unexpected: got beat %h, required no output", bus.opTxStream);
        end else begin
          e = expQ.pop_front();
          check("out_beat", 32'(bus.opTxStream), 32'(e));
        end
        if (tagMode) begin
          if (bus.opTxStream.SoP) begin
            check("atom_sop_open", 32'(inPkt), 0);
            curSrc = s;
          end else begin
            check("atom_cont", 32'(inPkt), 1);
            check("atom_src", s, curSrc);
          end
          inPkt = !bus.opTxStream.EoP;
        end
      end
    end
  endtask

  task automatic rdyDriver();
    forever begin
      @(posedge ipClk); #1;
      case (rdyMode)
        1:       bus.ipTxReady = ~bus.ipTxReady;
        2:       bus.ipTxReady = ($urandom_range(0, 3) != 0);
        default: bus.ipTxReady = 1'b1;
      endcase
    end
  endtask

  task automatic fairSrc(input int i);
    for (int p = 0; p < 3; p++) sendPkt(i, 2, {2'(i), 6'(p*2)}, 0);
  endtask

  task automatic randSrc(input int i);
    int n;
    n = $urandom_range(2, 5);
    for (int p = 0; p < n; p++) begin
      sendPkt(i, $urandom_range(1, 6), {2'(i), 6'($urandom_range(0, 40))}, 2);
      idle($urandom_range(0, 4));
    end
  endtask

  initial begin
    int w, mark, smark, pAt, pCnt;
    nCmp = 0; nErr = 0; cyc = 0; curSrc = 0; rdyMode = 0; drops = 0;
    tagMode = 0; toSeen = 0; inPkt = 0;
    for (int i = 0; i < NUM_IN; i++) src[i] = '0;
    bus.ipTxReady = 1'b1;
    nReset = 1'b1;
    fork
      monitor();
      rdyDriver();
      begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "bench hung");
      end
    join_none

    // reset state
    repeat (3) @(posedge ipClk);
    #1 nReset = 1'b0;
    @(negedge ipClk);
    check("rst_stream", 32'(bus.opTxStream), 0);
    check("rst_ready", 32'(bus.opTxReady), 0);
    check("rst_grant", 32'(bus.opGrant), 0);
    check("rst_timeout", 32'(bus.opTimeout), 0);
    check("rst_drops", 32'(bus.opDropCount), 0);
    @(posedge ipClk); #1;

    // single source, 4-beat packet
    mark = outCycs.size();
    fork
      sendPkt(0, 4, 8'hA1, 0);
      begin
        repeat (2) @(negedge ipClk);
        check("single_lat_valid", 32'(bus.opTxStream.Valid), 1);
        check("single_lat_data", 32'(bus.opTxStream.Data), 32'hA1);
        check("single_grant_on", 32'(bus.opGrant), 32'h1);
        repeat (3) @(negedge ipClk);
        check("single_last_data", 32'(bus.opTxStream.Data), 32'hA4);
        check("single_last_eop", 32'(bus.opTxStream.EoP), 1);
        check("single_grant_off", 32'(bus.opGrant), 0);
      end
    join
    idle(3);
    check("single_count", outCycs.size() - mark, 4);
    if (outCycs.size() - mark == 4) check("single_span", outCycs[mark+3] - outCycs[mark], 3);

    // orphan beats while idle
    mark = outCycs.size();
    for (int b = 0; b < 3; b++) begin
      sendBeat(2, mk(8'h20 + 8'(b), 1'b0, 1'b0), 1'b0, w);
      check("orphan_ready", w, 0);
    end
    drops += 3;
    @(negedge ipClk);
    check("orphan_drops", 32'(bus.opDropCount), drops);
    check("orphan_no_out", outCycs.size() - mark, 0);
    @(posedge ipClk); #1;

    // stalled owner: watchdog, resync drops, recovery
    sendBeat(1, mk(8'hB0, 1'b1, 1'b0), 1'b1, w);
    pAt = -1; pCnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ipClk);
      if (bus.opTimeout) begin
        pCnt++;
        if (pAt < 0) pAt = k;
      end
    end
    check("timeout_at", pAt, TIMEOUT);
    check("timeout_pulses", pCnt, 1);
    check("timeout_grant", 32'(bus.opGrant), 0);
    @(posedge ipClk); #1;
    sendBeat(1, mk(8'hB1, 1'b0, 1'b0), 1'b0, w);
    sendBeat(1, mk(8'hB2, 1'b0, 1'b1), 1'b0, w);
    drops += 2;
    @(negedge ipClk);
    check("resync_drops", 32'(bus.opDropCount), drops);
    @(posedge ipClk); #1;
    sendPkt(1, 3, 8'hC1, 0);
    idle(3);
    check("resync_recover", expQ.size(), 0);

    // output backpressure during an 8-beat packet
    toSeen = 0; mark = outCycs.size(); rdyMode = 1;
    sendPkt(3, 8, 8'h30, 0);
    rdyMode = 0;
    idle(4);
    check("bp_count", outCycs.size() - mark, 8);
    check("bp_empty", expQ.size(), 0);
    check("bp_no_timeout", 32'(toSeen), 0);

    // reset in the middle of a 5-beat packet
    sendBeat(0, mk(8'hD1, 1'b1, 1'b0), 1'b1, w);
    sendBeat(0, mk(8'hD2, 1'b0, 1'b0), 1'b1, w);
    src[0] = mk(8'hD3, 1'b0, 1'b0);
    nReset = 1'b1;
    @(posedge ipClk); #1;
    nReset = 1'b0; src[0] = '0; drops = 0;
    @(negedge ipClk);
    check("mid_rst_stream", 32'(bus.opTxStream), 0);
    check("mid_rst_ready", 32'(bus.opTxReady), 0);
    check("mid_rst_grant", 32'(bus.opGrant), 0);
    check("mid_rst_timeout", 32'(bus.opTimeout), 0);
    check("mid_rst_drops", 32'(bus.opDropCount), 0);
    check("mid_rst_drain", expQ.size(), 0);
    @(posedge ipClk); #1;

    // fairness: all inputs back-to-back; ptr restarted at 0 so input 1 leads
    tagMode = 1; mark = outCycs.size(); smark = sopSrc.size();
    fork
      fairSrc(0);
      fairSrc(1);
      fairSrc(2);
      fairSrc(3);
    join
    idle(3);
    check("fair_pkts", sopSrc.size() - smark, 12);
    if (sopSrc.size() - smark == 12)
      for (int k = 0; k < 12; k++) check($sformatf("fair_order%0d", k), sopSrc[smark+k], (k + 1) % NUM_IN);
    check("fair_beats", outCycs.size() - mark, 24);
    if (outCycs.size() - mark == 24) check("fair_no_bubble", outCycs[mark+23] - outCycs[mark], 23);

    // randomized traffic with random downstream ready
    toSeen = 0; rdyMode = 2;
    fork
      randSrc(0);
      randSrc(1);
      randSrc(2);
      randSrc(3);
    join
    rdyMode = 0;
    idle(10);
    check("rand_empty", expQ.size(), 0);
    check("rand_drops", 32'(bus.opDropCount), drops);
    check("rand_no_timeout", 32'(toSeen), 0);
    check("rand_grant_idle", 32'(bus.opGrant), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- N-input, packet-atomic, round-robin arbiter that merges NUM_IN UART_PACKET streams onto the single UART transmit path.
- Sits between packet producers (status/telemetry framers, command responders) and the UART transmitter.
- Holds one grant from SoP to EoP.
- Discards orphan beats, and recovers from a stalled source with a watchdog timeout.

Parameters:
- NUM_IN, 4, number of requesting streams (2..8).
- TIMEOUT, 1024, cycles without an accepted beat from the granted input before the grant is revoked.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- ipClk  in  1  clock.
- nReset  in  1  reset, synchronous, active-high; clock ipClk.
- ipTxStream  in  UART_PACKET[NUM_IN]  requester streams {Data[7:0], Valid, SoP, EoP}.
- opTxReady  out  NUM_IN  per-input ready, combinational.
- opTxStream  out  UART_PACKET  registered merged stream to the UART.
- ipTxReady  in  1  UART ready.
- opGrant  out  NUM_IN  one-hot current owner; 0 in IDLE.
- opTimeout  out  1  one-cycle pulse when a grant is revoked.
- opDropCount  out  CNT_W  saturating count of discarded beats.

Behaviour:
- Reset values: opTxStream all fields 0, opTxReady 0, opGrant 0, opTimeout 0, opDropCount 0, rr pointer 0, resync flags 0, state IDLE. Reset mid-packet aborts the packet with no EoP emitted.
- Handshake:
  - Input beat i transfers when ipTxStream[i].Valid && opTxReady[i].
  - Output beat transfers when opTxStream.Valid && ipTxReady.
  - slotFree = !opTxStream.Valid || ipTxReady.
  - Latency is 1 cycle from input transfer to opTxStream.Valid.
  - A full-rate, bubble-free stream is required when ipTxReady is held high.
- IDLE state:
  - Candidates are inputs with Valid && SoP && !resync[i].
  - The winner is the first candidate searching from ptr+1 modulo NUM_IN.
  - If there is a winner and slotFree: assert opTxReady[winner] combinationally, transfer the SoP beat, then go to LOCKED with opGrant = onehot(winner).
  - A single-beat packet (SoP && EoP) stays in IDLE and updates ptr.
- LOCKED state:
  - opTxReady[g] = slotFree. All other inputs hold ready 0, except drop cases.
  - Accepted beat with EoP: go to IDLE, ptr <= g, opGrant <= 0.
  - Accepted beat with SoP on g while LOCKED is a protocol error. Forward the beat unchanged and count it as a drop.
- Drops (any state):
  - A non-owner input presenting Valid && !SoP gets opTxReady 1. The beat is discarded and opDropCount increments.
  - An input with resync[i] set presenting Valid && !SoP is discarded the same way. Its SoP clears resync[i] and makes it a candidate again.
  - Multiple drops in one cycle add their count. The counter saturates at 2^CNT_W-1.
- Watchdog:
  - Counter resets on every accepted beat from g and on entry to LOCKED.
  - It counts only while the owner is not presenting Valid; output backpressure does not count.
  - Reaching TIMEOUT: pulse opTimeout, set resync[g], ptr <= g, go to IDLE.
  - No EoP is synthesised; the downstream framer detects truncation.
- Simultaneous events: an EoP accept and timeout expiry in the same cycle resolve as normal completion with no pulse.
- Arithmetic: ptr is $clog2(NUM_IN) bits. Wrap from NUM_IN-1 to 0 is explicit for non-power-of-two NUM_IN.

Decomposition:
- Shared package Structures holds:
  - UART_PACKET typedef (Data, Valid, SoP, EoP).
  - ARB_STATE enum {IDLE, LOCKED}.
- Sub-module rr_picker is purely combinational: request vector + pointer -> one-hot winner + valid. It is reusable by other schedulers.

Test Plan:
- Single source: input 0 sends 4-beat packet 0xA1..0xA4, ipTxReady=1 -> output 0xA1..0xA4 on 4 consecutive cycles, 1-cycle latency, EoP on 0xA4, opGrant=0001 then 0000.
- Fairness: NUM_IN=4, all inputs continuously offer 2-beat packets -> grant order 1,2,3,0,1..., no output bubbles, no input granted twice before the others.
- Backpressure: ipTxReady toggling 1,0,1,0 during an 8-beat packet -> all 8 bytes delivered in order, none duplicated, opTimeout stays 0.
- Orphans: input 2 sends 3 beats with SoP=0 while idle -> opTxReady[2] high, nothing on output, opDropCount=3.
- Timeout: TIMEOUT=16, input 1 sends SoP then stalls -> opTimeout pulse after 16 idle cycles. Its next 2 non-SoP beats are dropped (opDropCount +2). Its next SoP packet is forwarded normally.
- Reset mid-packet: assert nReset during beat 3 of 5 -> next cycle all outputs at reset values, ptr 0, drop count 0.
